// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if
// Bundles the signals between the UART command decoder and its neighbours.
//   Receive side : rxByte, rxStrobe, rxErr (from the UART receiver)
//   Response side: ackValid, ackByte (to the TX mux), ackTaken (from the TX mux)
//   Config side  : width, traceEn, ledCtl, errCount (to the trace marshaller / LEDs)
// The decoder uses the slave modport. The master modport is the view from the
// surrounding logic, such as the receiver, the TX mux or a testbench.
interface uart_cmd_decoder_if;
   logic [7:0] rxByte;
   logic       rxStrobe;
   logic       rxErr;
   logic [2:0] width;
   logic       traceEn;
   logic [3:0] ledCtl;
   logic       ackValid;
   logic [7:0] ackByte;
   logic       ackTaken;
   logic [7:0] errCount;

   // Surrounding logic drives the received bytes and the ack consumption.
   modport master (
      output rxByte, rxStrobe, rxErr, ackTaken,
      input  width, traceEn, ledCtl, ackValid, ackByte, errCount
   );

   // The decoder consumes bytes and drives the configuration and response.
   modport slave (
      input  rxByte, rxStrobe, rxErr, ackTaken,
      output width, traceEn, ledCtl, ackValid, ackByte, errCount
   );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Parses 4-byte host frames {0xA5, CMD, ARG, CHK} with CHK = 0xA5^CMD^ARG.
// A frame with a valid checksum updates the probe configuration registers.
// Every complete frame is answered with one ACK (0x06) or NAK (0x15) byte.
// The ACK/NAK byte is handed over through a valid/taken handshake.
// Ports:
//   clkOut : 48 MHz system clock
//   rst    : synchronous, active-high reset
//   bus    : uart_cmd_decoder_if.slave, which carries the rx byte strobe,
//            rxErr, the config outputs, the ack handshake and errCount
// Parameter:
//   TIMEOUT_CYCLES : longest idle gap allowed between the bytes of one frame
module uart_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 480000
) (
   input  logic                 clkOut,
   input  logic                 rst,
   uart_cmd_decoder_if.slave    bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

   typedef enum logic [2:0] {
      IDLE,
      GOT_HDR,
      GOT_CMD,
      GOT_ARG,
      RESP
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [7:0]    cmd_q, arg_q;
   logic [2:0]    width_q;
   logic          traceEn_q;
   logic [3:0]    ledCtl_q;
   logic [7:0]    ackByte_q;
   logic [7:0]    errCount_q;

   logic midFrame;
   logic timeoutHit;
   logic ackValid;
   logic latchCmd;
   logic latchArg;
   logic frameDone;
   logic errInc;
   logic chkOk;
   logic respAck;
   logic setWidth;
   logic setEnable;
   logic setLeds;

   assign midFrame   = (state_q == GOT_HDR) || (state_q == GOT_CMD) || (state_q == GOT_ARG);
   assign timeoutHit = midFrame && (timer_q == TW'(TIMEOUT_CYCLES));

   // State register. This holds the current frame parsing position.
   always_ff @(posedge clkOut) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Inside a frame, rxErr beats a same-cycle strobe.
   // A strobe beats a same-cycle timeout, so a byte that arrives exactly at
   // the limit still counts.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.rxStrobe && (bus.rxByte == HDR_BYTE)) begin
               state_d = GOT_HDR;
            end
         end
         GOT_HDR, GOT_CMD, GOT_ARG: begin
            if (bus.rxErr) begin
               state_d = IDLE;
            end else if (bus.rxStrobe) begin
               case (state_q)
                  GOT_HDR: state_d = GOT_CMD;
                  GOT_CMD: state_d = GOT_ARG;
                  default: state_d = RESP;
               endcase
            end else if (timeoutHit) begin
               state_d = IDLE;
            end
         end
         RESP: begin
            if (bus.ackTaken) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and action decode from the current state.
   // errInc covers mid-frame aborts (rxErr or timeout) and bytes that arrive
   // while the response is still waiting to be taken.
   always_comb begin
      ackValid  = (state_q == RESP);
      latchCmd  = (state_q == GOT_HDR) && bus.rxStrobe && !bus.rxErr;
      latchArg  = (state_q == GOT_CMD) && bus.rxStrobe && !bus.rxErr;
      frameDone = (state_q == GOT_ARG) && bus.rxStrobe && !bus.rxErr;
      errInc    = (midFrame && (bus.rxErr || (!bus.rxStrobe && timeoutHit)))
                  || ((state_q == RESP) && bus.rxStrobe);
   end

   // Command evaluation on the CHK byte. Only a matching checksum can select
   // a register update. Any failed check falls through to a NAK.
   always_comb begin
      chkOk     = (bus.rxByte == (HDR_BYTE ^ cmd_q ^ arg_q));
      respAck   = 1'b0;
      setWidth  = 1'b0;
      setEnable = 1'b0;
      setLeds   = 1'b0;
      if (chkOk) begin
         case (cmd_q)
            8'h01: begin
               if ((arg_q == 8'd1) || (arg_q == 8'd2) || (arg_q == 8'd4)) begin
                  setWidth = 1'b1;
                  respAck  = 1'b1;
               end
            end
            8'h02: begin
               setEnable = 1'b1;
               respAck   = 1'b1;
            end
            8'h03: begin
               setLeds = 1'b1;
               respAck = 1'b1;
            end
            8'h04: begin
               respAck = 1'b1;
            end
            default: respAck = 1'b0;
         endcase
      end
   end

   // Inter-byte timer. It restarts on every accepted byte and only runs
   // while a frame is partly received.
   always_comb begin
      if (midFrame && !bus.rxStrobe) begin
         timer_d = timer_q + TW'(1);
      end else begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clkOut) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   // Frame capture, configuration registers, response byte and the
   // saturating abort counter. ackByte only changes on frameDone, which
   // happens in GOT_ARG, so it is stable for the whole RESP period.
   always_ff @(posedge clkOut) begin
      if (rst) begin
         cmd_q      <= 8'h00;
         arg_q      <= 8'h00;
         width_q    <= 3'd4;
         traceEn_q  <= 1'b1;
         ledCtl_q   <= 4'h0;
         ackByte_q  <= 8'h00;
         errCount_q <= 8'h00;
      end else begin
         if (latchCmd) begin
            cmd_q <= bus.rxByte;
         end
         if (latchArg) begin
            arg_q <= bus.rxByte;
         end
         if (frameDone) begin
            ackByte_q <= respAck ? ACK_BYTE : NAK_BYTE;
            if (setWidth) begin
               width_q <= arg_q[2:0];
            end
            if (setEnable) begin
               traceEn_q <= arg_q[0];
            end
            if (setLeds) begin
               ledCtl_q <= arg_q[3:0];
            end
         end
         if (errInc && (errCount_q != 8'hFF)) begin
            errCount_q <= errCount_q + 8'd1;
         end
      end
   end

   assign bus.width    = width_q;
   assign bus.traceEn  = traceEn_q;
   assign bus.ledCtl   = ledCtl_q;
   assign bus.ackValid = ackValid;
   assign bus.ackByte  = ackByte_q;
   assign bus.errCount = errCount_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder
// Directed bench for uart_cmd_decoder with TIMEOUT_CYCLES = 100.
// A table of complete frames exercises the command set. Hand-written
// sequences then cover ack holding, timeouts, aborts, drops in RESP,
// reset mid-frame and errCount saturation.
module tb_uart_cmd_decoder;

   localparam int TMO = 100;

   logic clkOut;
   logic rst;
   int   errors;
   int   checks;

   uart_cmd_decoder_if bus ();

   uart_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
      .clkOut (clkOut),
      .rst    (rst),
      .bus    (bus)
   );

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] arg;
      logic [7:0] chk;
      logic [2:0] expWidth;
      logic       expEn;
      logic [3:0] expLed;
      logic [7:0] expAck;
   } vec_t;

   vec_t vecs [11];

   // Free-running 100 MHz-equivalent clock for simulation
   initial clkOut = 1'b0;
   always #5 clkOut = ~clkOut;

   // Compare one value and report it on a mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Strobe one byte. Returns just after the edge that sampled it
   task automatic applyStimulus(input logic [7:0] b);
      bus.rxByte   = b;
      bus.rxStrobe = 1'b1;
      @(posedge clkOut);
      #1;
      bus.rxStrobe = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clkOut);
         #1;
      end
   endtask

   task automatic sendFrame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
      applyStimulus(8'hA5);
      applyStimulus(c);
      applyStimulus(a);
      applyStimulus(k);
   endtask

   task automatic takeAck();
      bus.ackTaken = 1'b1;
      @(posedge clkOut);
      #1;
      bus.ackTaken = 1'b0;
   endtask

   task automatic pulseErr();
      bus.rxErr = 1'b1;
      @(posedge clkOut);
      #1;
      bus.rxErr = 1'b0;
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clkOut);
      #1;
      rst = 1'b0;
   endtask

   // Slow frame: each byte follows the previous one after 'gap' idle cycles
   task automatic sendSlowFrame(input int gap);
      applyStimulus(8'hA5);
      idleCycles(gap);
      applyStimulus(8'h04);
      idleCycles(gap);
      applyStimulus(8'h00);
      idleCycles(gap);
      applyStimulus(8'hA1);
   endtask

   // Main test sequence
   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.rxByte   = 8'h00;
      bus.rxStrobe = 1'b0;
      bus.rxErr    = 1'b0;
      bus.ackTaken = 1'b0;

      // cmd, arg, chk, width, traceEn, ledCtl, response (cumulative after reset)
      vecs[0]  = '{8'h01, 8'h03, 8'hA7, 3'd4, 1'b1, 4'h0, 8'h15};
      vecs[1]  = '{8'h02, 8'h00, 8'hA7, 3'd4, 1'b0, 4'h0, 8'h06};
      vecs[2]  = '{8'h03, 8'h0F, 8'h00, 3'd4, 1'b0, 4'h0, 8'h15};
      vecs[3]  = '{8'h03, 8'h0F, 8'hA9, 3'd4, 1'b0, 4'hF, 8'h06};
      vecs[4]  = '{8'h01, 8'h01, 8'hA5, 3'd1, 1'b0, 4'hF, 8'h06};
      vecs[5]  = '{8'h01, 8'h04, 8'hA0, 3'd4, 1'b0, 4'hF, 8'h06};
      vecs[6]  = '{8'h01, 8'h00, 8'hA4, 3'd4, 1'b0, 4'hF, 8'h15};
      vecs[7]  = '{8'h04, 8'h00, 8'hA1, 3'd4, 1'b0, 4'hF, 8'h06};
      vecs[8]  = '{8'h07, 8'h00, 8'hA2, 3'd4, 1'b0, 4'hF, 8'h15};
      vecs[9]  = '{8'h02, 8'hFF, 8'h58, 3'd4, 1'b1, 4'hF, 8'h06};
      vecs[10] = '{8'h03, 8'hF5, 8'h53, 3'd4, 1'b1, 4'h5, 8'h06};

      repeat (2) @(posedge clkOut);
      #1;
      rst = 1'b0;

      checkOutput("reset width", 32'(bus.width), 32'd4);
      checkOutput("reset traceEn", 32'(bus.traceEn), 32'd1);
      checkOutput("reset ledCtl", 32'(bus.ledCtl), 32'd0);
      checkOutput("reset ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("reset ackByte", 32'(bus.ackByte), 32'h00);
      checkOutput("reset errCount", 32'(bus.errCount), 32'd0);

      $display("[TB] SET_WIDTH 2 with held ack");
      sendFrame(8'h01, 8'h02, 8'hA6);
      checkOutput("w2 ackValid", 32'(bus.ackValid), 32'd1);
      checkOutput("w2 ackByte", 32'(bus.ackByte), 32'h06);
      checkOutput("w2 width", 32'(bus.width), 32'd2);
      for (int i = 0; i < 10; i++) begin
         idleCycles(1);
         checkOutput($sformatf("hold%0d ackValid", i), 32'(bus.ackValid), 32'd1);
         checkOutput($sformatf("hold%0d ackByte", i), 32'(bus.ackByte), 32'h06);
      end
      takeAck();
      checkOutput("w2 ackValid after take", 32'(bus.ackValid), 32'd0);
      takeAck();
      checkOutput("stray ackTaken ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("stray ackTaken errCount", 32'(bus.errCount), 32'd0);

      doReset();
      checkOutput("re-reset width", 32'(bus.width), 32'd4);

      $display("[TB] command table");
      for (int i = 0; i < 11; i++) begin
         sendFrame(vecs[i].cmd, vecs[i].arg, vecs[i].chk);
         checkOutput($sformatf("vec%0d ackValid", i), 32'(bus.ackValid), 32'd1);
         checkOutput($sformatf("vec%0d ackByte", i), 32'(bus.ackByte), 32'(vecs[i].expAck));
         checkOutput($sformatf("vec%0d width", i), 32'(bus.width), 32'(vecs[i].expWidth));
         checkOutput($sformatf("vec%0d traceEn", i), 32'(bus.traceEn), 32'(vecs[i].expEn));
         checkOutput($sformatf("vec%0d ledCtl", i), 32'(bus.ledCtl), 32'(vecs[i].expLed));
         checkOutput($sformatf("vec%0d errCount", i), 32'(bus.errCount), 32'd0);
         takeAck();
         checkOutput($sformatf("vec%0d ackValid after take", i), 32'(bus.ackValid), 32'd0);
      end

      $display("[TB] inter-byte timeout");
      applyStimulus(8'hA5);
      applyStimulus(8'h04);
      idleCycles(TMO + 5);
      checkOutput("timeout ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("timeout errCount", 32'(bus.errCount), 32'd1);
      sendSlowFrame(TMO - 1);
      checkOutput("gap99 ackValid", 32'(bus.ackValid), 32'd1);
      checkOutput("gap99 ackByte", 32'(bus.ackByte), 32'h06);
      checkOutput("gap99 errCount", 32'(bus.errCount), 32'd1);
      takeAck();
      sendSlowFrame(TMO);
      checkOutput("gap100 ackValid", 32'(bus.ackValid), 32'd1);
      checkOutput("gap100 ackByte", 32'(bus.ackByte), 32'h06);
      checkOutput("gap100 errCount", 32'(bus.errCount), 32'd1);
      takeAck();

      $display("[TB] rxErr aborts and garbage");
      applyStimulus(8'hA5);
      applyStimulus(8'h03);
      pulseErr();
      checkOutput("rxErr abort errCount", 32'(bus.errCount), 32'd2);
      applyStimulus(8'h0F);
      applyStimulus(8'hA9);
      checkOutput("post-abort ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("post-abort ledCtl", 32'(bus.ledCtl), 32'h5);
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      checkOutput("garbage errCount", 32'(bus.errCount), 32'd2);
      pulseErr();
      checkOutput("idle rxErr errCount", 32'(bus.errCount), 32'd2);
      applyStimulus(8'hA5);
      bus.rxByte   = 8'h04;
      bus.rxStrobe = 1'b1;
      bus.rxErr    = 1'b1;
      @(posedge clkOut);
      #1;
      bus.rxStrobe = 1'b0;
      bus.rxErr    = 1'b0;
      checkOutput("strobe+rxErr errCount", 32'(bus.errCount), 32'd3);
      applyStimulus(8'h00);
      applyStimulus(8'hA1);
      checkOutput("strobe+rxErr ackValid", 32'(bus.ackValid), 32'd0);

      $display("[TB] bytes during RESP");
      sendFrame(8'h04, 8'h00, 8'hA1);
      applyStimulus(8'h11);
      checkOutput("resp drop errCount", 32'(bus.errCount), 32'd4);
      checkOutput("resp drop ackValid", 32'(bus.ackValid), 32'd1);
      checkOutput("resp drop ackByte", 32'(bus.ackByte), 32'h06);
      pulseErr();
      checkOutput("resp rxErr errCount", 32'(bus.errCount), 32'd4);
      bus.ackTaken = 1'b1;
      bus.rxByte   = 8'hA5;
      bus.rxStrobe = 1'b1;
      @(posedge clkOut);
      #1;
      bus.ackTaken = 1'b0;
      bus.rxStrobe = 1'b0;
      checkOutput("handshake+hdr ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("handshake+hdr errCount", 32'(bus.errCount), 32'd5);
      sendFrame(8'h01, 8'h02, 8'hA6);
      checkOutput("next frame ackByte", 32'(bus.ackByte), 32'h06);
      checkOutput("next frame width", 32'(bus.width), 32'd2);
      takeAck();
      sendFrame(8'h02, 8'h00, 8'hA7);
      checkOutput("en0 traceEn", 32'(bus.traceEn), 32'd0);
      takeAck();

      $display("[TB] reset between ARG and CHK");
      applyStimulus(8'hA5);
      applyStimulus(8'h03);
      applyStimulus(8'h0A);
      doReset();
      checkOutput("midrst width", 32'(bus.width), 32'd4);
      checkOutput("midrst traceEn", 32'(bus.traceEn), 32'd1);
      checkOutput("midrst ledCtl", 32'(bus.ledCtl), 32'd0);
      checkOutput("midrst ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("midrst ackByte", 32'(bus.ackByte), 32'h00);
      checkOutput("midrst errCount", 32'(bus.errCount), 32'd0);
      applyStimulus(8'hAC);
      checkOutput("post-rst chk ackValid", 32'(bus.ackValid), 32'd0);
      checkOutput("post-rst chk ledCtl", 32'(bus.ledCtl), 32'd0);

      $display("[TB] errCount saturation");
      for (int i = 0; i < 300; i++) begin
         applyStimulus(8'hA5);
         pulseErr();
         if (i == 253) begin
            checkOutput("sat 254 errCount", 32'(bus.errCount), 32'd254);
         end
         if (i == 254) begin
            checkOutput("sat 255 errCount", 32'(bus.errCount), 32'd255);
         end
      end
      checkOutput("sat 300 errCount", 32'(bus.errCount), 32'hFF);
      checkOutput("sat ackValid", 32'(bus.ackValid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
